cmp_tracker: RTL and testbench

CMP_TRACKER -- requirements
Module: cmp_tracker

---
 rtl/cmp_pkg.sv | 16 +
 rtl/cmp_core.sv | 31 +++
 rtl/cmp_tracker.sv | 147 ++++++++++++++
 tb/tb_cmp_tracker.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types for the compare tracker: result classes and tracking FSM states.
package cmp_pkg;

  typedef enum logic [1:0] {
    CMP_EQ = 2'd0,
    CMP_GT = 2'd1,
    CMP_LT = 2'd2
  } cmp_class_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    STABLE = 2'd2
  } state_t;

endpackage

// File: rtl/cmp_core.sv
// Combinational magnitude compare of two operands, signed or unsigned.
module cmp_core
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode_signed,
  output cmp_class_t       res_class
);

  logic [WIDTH:0] w_aExt;
  logic [WIDTH:0] w_bExt;
  logic [WIDTH:0] w_diff;

  // One extra bit keeps the subtraction exact, so its MSB is the true sign.
  assign w_aExt = {mode_signed & a[WIDTH-1], a};
  assign w_bExt = {mode_signed & b[WIDTH-1], b};
  assign w_diff = w_aExt - w_bExt;

  always_comb begin
    res_class = CMP_GT;
    if (w_diff == '0) begin
      res_class = CMP_EQ;
    end else if (w_diff[WIDTH]) begin
      res_class = CMP_LT;
    end
  end

endmodule

// File: rtl/cmp_tracker.sv
// Registered compare with valid/ready handshake and result-stability tracking.
// Define CMP_TRACKER_STATS_EN to add saturating per-class counters.
module cmp_tracker
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             mode_signed,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             equal,
  output logic             greater,
  output logic             lower,
  output logic             stable
`ifdef CMP_TRACKER_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt_eq,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_lt
`endif
);

  localparam int RUN_W = $clog2(STABLE_CNT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CNT);

  cmp_class_t       w_class;
  logic             w_accept;
  logic             r_outValid;
  logic             r_equal;
  logic             r_greater;
  logic             r_lower;
  state_t           r_state;
  state_t           w_stateNext;
  logic [RUN_W-1:0] r_run;
  logic [RUN_W-1:0] w_runNext;
  cmp_class_t       r_prevClass;
  cmp_class_t       w_prevNext;

  cmp_core #(.WIDTH(WIDTH)) u_core (
    .a           (a),
    .b           (b),
    .mode_signed (mode_signed),
    .res_class   (w_class)
  );

  // Held low during reset so nothing is taken while the block is cleared.
  assign in_ready = rst_n && !clr && (!r_outValid || out_ready);
  assign w_accept = in_valid && in_ready;

  assign out_valid = r_outValid;
  assign equal     = r_equal;
  assign greater   = r_greater;
  assign lower     = r_lower;
  assign stable    = (r_state == STABLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_equal    <= 1'b0;
      r_greater  <= 1'b0;
      r_lower    <= 1'b0;
    end else if (clr) begin
      r_outValid <= 1'b0;
      r_equal    <= 1'b0;
      r_greater  <= 1'b0;
      r_lower    <= 1'b0;
    end else if (w_accept) begin
      r_outValid <= 1'b1;
      r_equal    <= (w_class == CMP_EQ);
      r_greater  <= (w_class == CMP_GT);
      r_lower    <= (w_class == CMP_LT);
    end else if (out_ready) begin
      r_outValid <= 1'b0;
      r_equal    <= 1'b0;
      r_greater  <= 1'b0;
      r_lower    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_run       <= '0;
      r_prevClass <= CMP_EQ;
    end else begin
      r_state     <= w_stateNext;
      r_run       <= w_runNext;
      r_prevClass <= w_prevNext;
    end
  end

  // A run of matching classes saturates at STABLE_CNT; any change restarts it at 1.
  always_comb begin
    w_stateNext = r_state;
    w_runNext   = r_run;
    w_prevNext  = r_prevClass;
    if (clr) begin
      w_stateNext = IDLE;
      w_runNext   = '0;
      w_prevNext  = CMP_EQ;
    end else if (w_accept) begin
      if ((r_state != IDLE) && (w_class == r_prevClass)) begin
        w_runNext = (r_run == RUN_MAX) ? r_run : r_run + 1'b1;
      end else begin
        w_runNext = RUN_W'(1);
      end
      w_prevNext  = w_class;
      w_stateNext = (w_runNext == RUN_MAX) ? STABLE : TRACK;
    end
  end

`ifdef CMP_TRACKER_STATS_EN
  logic [CNT_W-1:0] r_cntEq;
  logic [CNT_W-1:0] r_cntGt;
  logic [CNT_W-1:0] r_cntLt;

  assign cnt_eq = r_cntEq;
  assign cnt_gt = r_cntGt;
  assign cnt_lt = r_cntLt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cntEq <= '0;
      r_cntGt <= '0;
      r_cntLt <= '0;
    end else if (clr) begin
      r_cntEq <= '0;
      r_cntGt <= '0;
      r_cntLt <= '0;
    end else if (w_accept) begin
      if ((w_class == CMP_EQ) && (r_cntEq != '1)) r_cntEq <= r_cntEq + 1'b1;
      if ((w_class == CMP_GT) && (r_cntGt != '1)) r_cntGt <= r_cntGt + 1'b1;
      if ((w_class == CMP_LT) && (r_cntLt != '1)) r_cntLt <= r_cntLt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cmp_tracker.sv
// Directed bench for cmp_tracker: table of compare vectors plus handshake,
// stability, flush and reset sequences (statistics checks with CMP_TRACKER_STATS_EN).
module tb_cmp_tracker;
  import cmp_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       mode_signed;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic       equal;
  logic       greater;
  logic       lower;
  logic       stable;
`ifdef CMP_TRACKER_STATS_EN
  logic [1:0] cnt_eq;
  logic [1:0] cnt_gt;
  logic [1:0] cnt_lt;
`endif

  int testCount = 0;
  int failCount = 0;

  typedef struct {
    logic       ms;
    logic [7:0] va;
    logic [7:0] vb;
    logic [2:0] expFlags;
  } vec_t;

  vec_t vecs [12];

  cmp_tracker #(.WIDTH(8), .STABLE_CNT(4), .CNT_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .mode_signed (mode_signed),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .equal       (equal),
    .greater     (greater),
    .lower       (lower),
    .stable      (stable)
`ifdef CMP_TRACKER_STATS_EN
    ,
    .cnt_eq      (cnt_eq),
    .cnt_gt      (cnt_gt),
    .cnt_lt      (cnt_lt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic valid, input logic ms, input logic [7:0] va,
                               input logic [7:0] vb, input logic ordy);
    in_valid    = valid;
    mode_signed = ms;
    a           = va;
    b           = vb;
    out_ready   = ordy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Flags are checked as one vector {out_valid, equal, greater, lower}.
  function automatic logic [31:0] flags();
    return {28'd0, out_valid, equal, greater, lower};
  endfunction

  initial begin
    vecs[0]  = '{1'b1, 8'h80, 8'h7F, 3'b001};
    vecs[1]  = '{1'b0, 8'h80, 8'h7F, 3'b010};
    vecs[2]  = '{1'b1, 8'hFF, 8'hFF, 3'b100};
    vecs[3]  = '{1'b0, 8'hFF, 8'hFF, 3'b100};
    vecs[4]  = '{1'b1, 8'hFF, 8'h01, 3'b001};
    vecs[5]  = '{1'b0, 8'hFF, 8'h01, 3'b010};
    vecs[6]  = '{1'b1, 8'h7F, 8'h80, 3'b010};
    vecs[7]  = '{1'b0, 8'h00, 8'h01, 3'b001};
    vecs[8]  = '{1'b1, 8'h05, 8'h03, 3'b010};
    vecs[9]  = '{1'b0, 8'h00, 8'h00, 3'b100};
    vecs[10] = '{1'b1, 8'h80, 8'h80, 3'b100};
    vecs[11] = '{1'b1, 8'h81, 8'h80, 3'b010};

    rst_n = 1'b0;
    clr   = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    #2;
    checkOutput("reset_flags", flags(), 32'h0);
    checkOutput("reset_stable", 32'(stable), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back stream: one result per cycle, latency 1.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, vecs[i].ms, vecs[i].va, vecs[i].vb, 1'b1);
      checkOutput($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      step();
      checkOutput($sformatf("vec%0d_flags", i), flags(), {28'd0, 1'b1, vecs[i].expFlags});
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    step();
    checkOutput("drain_flags", flags(), 32'h0);

    // Stability: four equal pairs, then class changes.
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h07, 8'h07, 1'b1);
      step();
      checkOutput($sformatf("stab_eq%0d_flags", i), flags(), 32'b1100);
      checkOutput($sformatf("stab_eq%0d_stable", i), 32'(stable), (i == 3) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 8'h09, 8'h02, 1'b1);
    step();
    checkOutput("stab_gt_flags", flags(), 32'b1010);
    checkOutput("stab_gt_stable", 32'(stable), 32'd0);
    checkOutput("stab_gt_state", 32'(dut.r_state), 32'(TRACK));
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("stab_gtrun%0d_stable", i), 32'(stable), (i == 2) ? 32'd1 : 32'd0);
    end

    // Backpressure: result held for three cycles, new pair refused.
    clr = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step();
    clr = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'd5, 8'd3, 1'b0);
    step();
    applyStimulus(1'b1, 1'b0, 8'd1, 8'd9, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("bp%0d_flags", i), flags(), 32'b1010);
      checkOutput($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
      step();
    end
    applyStimulus(1'b0, 1'b0, 8'd1, 8'd9, 1'b1);
    #1;
    checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
    step();
    checkOutput("bp_after_transfer", flags(), 32'h0);

`ifdef CMP_TRACKER_STATS_EN
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 8'hF0, 8'h10, 1'b1);
      step();
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    step();
    checkOutput("stats_cnt_lt_sat", 32'(cnt_lt), 32'd3);
    checkOutput("stats_cnt_eq", 32'(cnt_eq), 32'd0);
    checkOutput("stats_cnt_gt", 32'(cnt_gt), 32'd0);
`endif

    // Flush with a pending result and an offered pair.
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h04, 8'h04, 1'b1);
      step();
    end
    applyStimulus(1'b1, 1'b0, 8'h04, 8'h04, 1'b0);
    step();
    checkOutput("flush_pre_stable", 32'(stable), 32'd1);
    checkOutput("flush_pre_flags", flags(), 32'b1100);
    clr = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h09, 8'h01, 1'b0);
    #1;
    checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    checkOutput("flush_flags", flags(), 32'h0);
    checkOutput("flush_stable", 32'(stable), 32'd0);
    checkOutput("flush_state", 32'(dut.r_state), 32'(IDLE));
`ifdef CMP_TRACKER_STATS_EN
    checkOutput("flush_cnt_eq", 32'(cnt_eq), 32'd0);
`endif
    clr = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    step();
    checkOutput("flush_no_accept", flags(), 32'h0);

    // Reset pulsed while a result is stalled.
    applyStimulus(1'b1, 1'b0, 8'd5, 8'd3, 1'b0);
    step();
    checkOutput("rst_pre_flags", flags(), 32'b1010);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_flags", flags(), 32'h0);
    checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    checkOutput("rst_release_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h10, 8'h20, 1'b1);
    step();
    checkOutput("rst_after_flags", flags(), 32'b1001);
    checkOutput("rst_after_stable", 32'(stable), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
